router_dst_port_bank: RTL and testbench
=======================================

// Module: router_dst_port_bank
// PURPOSE
//  Parametrised N-channel destination output stage of the router: one FIFO per
//  destination port, written from the shared router datapath and drained by each
//  destination through the vld_out/read_enb handshake. Generalises the fixed
//  3-port 8-bit destination side to any width/depth/port count.
//  Adds per-port read-timeout flush (soft_reset) and write-drop reporting.
// PARAMETERS
//  DATA_W   8   data word width
//  DEPTH    16  words per channel FIFO (power of 2, >=2)
//  N_CH     3   number of destination ports (>=2); CH_W = $clog2(N_CH)
//  TIMEOUT  30  consecutive unread cycles with vld_out high before flush
// PORTS
//  clock       in   1             single clock, all state on posedge
//  reset       in   1             asynchronous, active-high
//  wr_en       in   1             write strobe from router datapath
//  wr_ch       in   CH_W          target channel for this write
//  data_in     in   DATA_W        write data
//  read_enb    in   N_CH          per-port read request from destination
//  data_out    out  N_CH*DATA_W   port i data at [i*DATA_W +: DATA_W]
//  vld_out     out  N_CH          port i FIFO non-empty
//  full        out  N_CH          port i FIFO holds DEPTH words
//  soft_reset  out  N_CH          1-cycle pulse: port i flushed on timeout
//  wr_drop     out  1             1-cycle pulse: write rejected
// BEHAVIOUR
//  - Reset (async): all FIFOs empty, pointers/counts 0, data_out 0, vld_out 0,
//    full 0, soft_reset 0, wr_drop 0, timeout counters 0.
//  - Write: wr_en & wr_ch<N_CH & !full[wr_ch] -> word stored at edge; vld_out
//    rises the cycle after the first write (1-cycle write-to-valid latency).
//  - Write rejected (wr_drop=1 next cycle, FIFO unchanged) when full[wr_ch],
//    wr_ch>=N_CH, or port wr_ch is flushing this cycle.
//  - Read: read_enb[i] & vld_out[i] -> head word registered onto data_out slice
//    i at the edge (1-cycle latency), read pointer advances. read_enb with
//    vld_out low ignored. data_out slice holds last value otherwise.
//  - Simultaneous read+write same port: both occur, count unchanged; permitted
//    when full (read frees slot same edge -> write accepted).
//  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1; full = count==DEPTH.
//  - Timeout FSM per port: IDLE (vld_out=0 or read_enb=1, counter cleared) ->
//    WAIT (vld_out=1 & read_enb=0, counter++) -> at counter==TIMEOUT-1 with no
//    read: FLUSH for one edge: pointers/count cleared, soft_reset[i]=1 for
//    exactly one cycle, data_out slice unchanged -> IDLE. A read in any WAIT
//    cycle returns to IDLE with counter 0.
//  - Ports fully independent; flush of port i never affects port j.
//  - Reset mid-transfer discards all stored words; no partial state survives.
// CONFIGURATION
//  ROUTER_DST_TIMEOUT_EN defined: timeout FSM and flush as above.
//  Not defined: no timeout logic; soft_reset tied 0; data held indefinitely;
//  TIMEOUT parameter unused.
// TESTING
//  1. Reset, write 0xA5,0x5A to ch1, read_enb[1]=1 -> vld_out=3'b010 after first
//     write; data_out[15:8]=0xA5 then 0x5A; vld_out[1] drops after second read.
//  2. Write 16 words to ch0 -> full[0]=1; 17th write -> wr_drop pulse, FIFO
//     still 16; read+write same cycle while full -> write accepted, full stays 1.
//  3. Write ch2 once, hold read_enb[2]=0 30 cycles -> soft_reset[2] pulses once
//     on cycle 30, vld_out[2]=0 next cycle; ch0/ch1 contents intact.
//  4. Same as 3 but read_enb[2]=1 on cycle 29 -> no soft_reset, word delivered.
//  5. wr_ch=3 with N_CH=3 -> wr_drop=1, no vld_out change.
//  6. Assert reset mid-burst with 5 words in ch0 -> all outputs 0 immediately
//     (async), ch0 empty after release. Repeat 3 without ROUTER_DST_TIMEOUT_EN ->
//     soft_reset stays 0, word retained.

Source files
------------

// File: rtl/router_dst_port_bank.sv
// Destination output stage: one FIFO per router port, drained by vld_out/read_enb.
// Optional read-timeout flush is built when ROUTER_DST_TIMEOUT_EN is defined.
module router_dst_port_bank #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int N_CH    = 3,
  parameter int TIMEOUT = 30,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [N_CH-1:0]          read_enb,
  output logic [N_CH*DATA_W-1:0]   data_out,
  output logic [N_CH-1:0]          vld_out,
  output logic [N_CH-1:0]          full,
  output logic [N_CH-1:0]          soft_reset,
  output logic                     wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N_CH-1:0] rd_fire;
  logic [N_CH-1:0] wr_ok;
  logic [N_CH-1:0] flush;

  assign rd_fire = read_enb & vld_out;

  // a write nobody accepted is reported one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_drop <= 1'b0;
    else       wr_drop <= wr_en && (wr_ok == '0);
  end

`ifndef ROUTER_DST_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] dout;
    logic              sel;

    assign sel      = wr_en && (wr_ch == CH_W'(i));
    assign wr_ok[i] = sel && (!full[i] || rd_fire[i]) && !flush[i];
    assign vld_out[i] = (count != '0);
    assign full[i]    = (count == CW'(DEPTH));
    assign data_out[i*DATA_W +: DATA_W] = dout;

    // storage array; contents are only meaningful below count
    always_ff @(posedge clock) begin
      if (wr_ok[i]) mem[wr_ptr] <= data_in;
    end

    // pointers and occupancy; a flush empties the port in one edge
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (flush[i]) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_ok[i])   wr_ptr <= wr_ptr + 1'b1;
        if (rd_fire[i]) rd_ptr <= rd_ptr + 1'b1;
        unique case (1'b1)
          wr_ok[i] && !rd_fire[i]: count <= count + 1'b1;
          rd_fire[i] && !wr_ok[i]: count <= count - 1'b1;
          default: ;
        endcase
      end
    end

    // head word is registered onto this port's slice on a read
    always_ff @(posedge clock or posedge reset) begin
      if (reset)           dout <= '0;
      else if (rd_fire[i]) dout <= mem[rd_ptr];
    end

`ifdef ROUTER_DST_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_WAIT} to_state_t;

    to_state_t       state;
    to_state_t       state_n;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_n;
    logic            flush_c;
    logic            waiting;

    assign waiting       = vld_out[i] && !read_enb[i];
    assign flush[i]      = flush_c;
    assign soft_reset[i] = flush_c;

    // timeout state and unread-cycle counter
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    end

    // count consecutive unread valid cycles; flush on the last one
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      flush_c = 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt_n = '0;
          if (waiting) begin
            if (TIMEOUT == 1) begin
              flush_c = 1'b1;
            end else begin
              state_n = S_WAIT;
              cnt_n   = TO_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (!waiting) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (cnt == TO_W'(TIMEOUT - 1)) begin
            flush_c = 1'b1;
            state_n = S_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
`else
    assign flush[i]      = 1'b0;
    assign soft_reset[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_router_dst_port_bank.sv
// Randomised and directed bench for router_dst_port_bank.
// Reference model: per-port word queues plus unread-cycle counters.
module tb_router_dst_port_bank;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int NCH     = 3;
  localparam int TIMEOUT = 30;
`ifdef ROUTER_DST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [7:0]    data_in;
  logic [2:0]    read_enb;
  logic [23:0]   data_out;
  logic [2:0]    vld_out;
  logic [2:0]    full;
  logic [2:0]    soft_reset;
  logic          wr_drop;

  router_dst_port_bank #(
    .DATA_W(DW), .DEPTH(DEPTH), .N_CH(NCH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clk), .reset(rst), .wr_en(wr_en), .wr_ch(wr_ch),
    .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
    .vld_out(vld_out), .full(full), .soft_reset(soft_reset),
    .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q [3][$];
  logic [7:0] dout_m [3];
  int         wcnt [3];
  logic [2:0] exp_sr;
  logic [2:0] got_sr;
  logic       exp_drop;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      dout_m[i] = 8'h00;
      wcnt[i]   = 0;
    end
  endtask

  // drive one cycle, sample soft_reset before the edge, advance the model
  task automatic tick(input logic we, input logic [1:0] ch,
                      input logic [7:0] d, input logic [2:0] re);
    logic [2:0] vm;
    logic [2:0] fl;
    logic       acc;
    wr_en = we; wr_ch = ch; data_in = d; read_enb = re;
    #1;
    got_sr = soft_reset;
    acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vm[i] = (q[i].size() != 0);
      fl[i] = TO_EN && vm[i] && !re[i] && (wcnt[i] == TIMEOUT - 1);
    end
    exp_sr = fl;
    for (int i = 0; i < 3; i++)
      if (re[i] && vm[i]) dout_m[i] = q[i].pop_front();
    if (we && ch < 2'd3) begin
      if (q[ch].size() < DEPTH && !fl[ch]) begin
        q[ch].push_back(d);
        acc = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (fl[i]) q[i].delete();
      if (vm[i] && !re[i] && !fl[i]) wcnt[i]++;
      else wcnt[i] = 0;
    end
    exp_drop = we && !acc;
    @(posedge clk);
    #1;
    wr_en = 1'b0; read_enb = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_ch = 2'd0; data_in = 8'h00; read_enb = 3'b000;
    model_clear();
    @(posedge clk); #1;
    n_tests++;
    if (data_out !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", data_out); end
    n_tests++;
    if (vld_out !== 3'b000) begin n_fail++; $display("FAIL reset_vld got %b exp 000", vld_out); end
    n_tests++;
    if (full !== 3'b000) begin n_fail++; $display("FAIL reset_full got %b exp 000", full); end
    n_tests++;
    if (soft_reset !== 3'b000 || wr_drop !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses got sr=%b drop=%b exp 0", soft_reset, wr_drop);
    end
    rst = 1'b0;
    tick(1'b0, 2'd0, 8'h00, 3'b000);
  endtask

  task automatic test_basic();
    tick(1'b1, 2'd1, 8'hA5, 3'b000);
    n_tests++;
    if (vld_out !== 3'b010) begin n_fail++; $display("FAIL basic_vld1 got %b exp 010", vld_out); end
    tick(1'b1, 2'd1, 8'h5A, 3'b000);
    tick(1'b0, 2'd0, 8'h00, 3'b010);
    n_tests++;
    if (data_out[15:8] !== 8'hA5 || vld_out !== 3'b010) begin
      n_fail++; $display("FAIL basic_rd1 got %h/%b exp a5/010", data_out[15:8], vld_out);
    end
    tick(1'b0, 2'd0, 8'h00, 3'b010);
    n_tests++;
    if (data_out[15:8] !== 8'h5A || vld_out !== 3'b000) begin
      n_fail++; $display("FAIL basic_rd2 got %h/%b exp 5a/000", data_out[15:8], vld_out);
    end
  endtask

  task automatic test_full();
    logic [7:0] w [16];
    for (int k = 0; k < 16; k++) begin
      w[k] = 8'($urandom);
      tick(1'b1, 2'd0, w[k], 3'b000);
    end
    n_tests++;
    if (full !== 3'b001 || vld_out !== 3'b001) begin
      n_fail++; $display("FAIL full_set got full=%b vld=%b exp 001/001", full, vld_out);
    end
    tick(1'b1, 2'd0, 8'hEE, 3'b000);
    n_tests++;
    if (wr_drop !== 1'b1 || full !== 3'b001) begin
      n_fail++; $display("FAIL full_drop got drop=%b full=%b exp 1/001", wr_drop, full);
    end
    tick(1'b1, 2'd0, 8'hC3, 3'b001);
    n_tests++;
    if (wr_drop !== 1'b0 || full !== 3'b001 || data_out[7:0] !== w[0]) begin
      n_fail++;
      $display("FAIL full_rw got drop=%b full=%b d=%h exp 0/001/%h",
               wr_drop, full, data_out[7:0], w[0]);
    end
    for (int k = 0; k < 16; k++) begin
      logic [7:0] e;
      e = (k == 15) ? 8'hC3 : w[k+1];
      tick(1'b0, 2'd0, 8'h00, 3'b001);
      n_tests++;
      if (data_out[7:0] !== e) begin
        n_fail++; $display("FAIL full_drain%0d got %h exp %h", k, data_out[7:0], e);
      end
    end
    n_tests++;
    if (vld_out[0] !== 1'b0) begin n_fail++; $display("FAIL full_empty got %b exp 0", vld_out[0]); end
  endtask

  task automatic test_bad_ch();
    tick(1'b1, 2'd3, 8'h77, 3'b000);
    n_tests++;
    if (wr_drop !== 1'b1 || vld_out !== 3'b000) begin
      n_fail++; $display("FAIL badch got drop=%b vld=%b exp 1/000", wr_drop, vld_out);
    end
    tick(1'b0, 2'd0, 8'h00, 3'b000);
    n_tests++;
    if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL badch_pulse got %b exp 0", wr_drop); end
  endtask

  task automatic test_timeout();
    logic [2:0] e;
    tick(1'b1, 2'd2, 8'h3C, 3'b000);
    for (int k = 1; k <= 30; k++) begin
      tick(k == 10 || k == 11, (k == 10) ? 2'd0 : 2'd1,
           (k == 10) ? 8'h0A : 8'h1B, 3'b000);
      e = (TO_EN && k == 30) ? 3'b100 : 3'b000;
      n_tests++;
      if (got_sr !== e) begin n_fail++; $display("FAIL tmo_sr%0d got %b exp %b", k, got_sr, e); end
    end
    n_tests++;
    if (vld_out !== {!TO_EN, 2'b11}) begin
      n_fail++; $display("FAIL tmo_vld got %b exp %b", vld_out, {!TO_EN, 2'b11});
    end
    tick(1'b0, 2'd0, 8'h00, 3'b011);
    n_tests++;
    if (data_out[15:0] !== 16'h1B0A) begin
      n_fail++; $display("FAIL tmo_other got %h exp 1b0a", data_out[15:0]);
    end
    if (!TO_EN) begin
      tick(1'b0, 2'd0, 8'h00, 3'b100);
      n_tests++;
      if (data_out[23:16] !== 8'h3C || got_sr !== 3'b000) begin
        n_fail++; $display("FAIL tmo_keep got %h sr=%b exp 3c/000", data_out[23:16], got_sr);
      end
    end
  endtask

  task automatic test_rescue();
    tick(1'b1, 2'd2, 8'h6D, 3'b000);
    for (int k = 1; k <= 32; k++) begin
      tick(1'b0, 2'd0, 8'h00, (k == 29) ? 3'b100 : 3'b000);
      n_tests++;
      if (got_sr !== 3'b000) begin n_fail++; $display("FAIL rescue_sr%0d got %b exp 000", k, got_sr); end
    end
    n_tests++;
    if (data_out[23:16] !== 8'h6D || vld_out[2] !== 1'b0) begin
      n_fail++; $display("FAIL rescue_data got %h/%b exp 6d/0", data_out[23:16], vld_out[2]);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) tick(1'b1, 2'd0, 8'h21 + 8'(k), 3'b000);
    tick(1'b0, 2'd0, 8'h00, 3'b001);
    n_tests++;
    if (data_out[7:0] !== 8'h21) begin n_fail++; $display("FAIL mid_pre got %h exp 21", data_out[7:0]); end
    wr_en = 1'b1; wr_ch = 2'd0; data_in = 8'h99;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (vld_out !== 3'b000 || full !== 3'b000 || data_out !== 24'h0 ||
        soft_reset !== 3'b000 || wr_drop !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async got vld=%b full=%b d=%h sr=%b drop=%b exp all 0",
               vld_out, full, data_out, soft_reset, wr_drop);
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    model_clear();
    tick(1'b0, 2'd0, 8'h00, 3'b001);
    n_tests++;
    if (vld_out !== 3'b000 || data_out !== 24'h0) begin
      n_fail++; $display("FAIL mid_after got vld=%b d=%h exp 000/0", vld_out, data_out);
    end
  endtask

  task automatic test_random();
    logic [2:0]  ev;
    logic [2:0]  ef;
    logic [23:0] ed;
    for (int n = 0; n < 400; n++) begin
      logic [2:0] re;
      for (int i = 0; i < 3; i++) re[i] = ($urandom_range(0, 2) == 0);
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom), re);
      for (int i = 0; i < 3; i++) begin
        ev[i] = (q[i].size() != 0);
        ef[i] = (q[i].size() == DEPTH);
        ed[i*8 +: 8] = dout_m[i];
      end
      n_tests++;
      if (vld_out !== ev) begin n_fail++; $display("FAIL rnd_vld%0d got %b exp %b", n, vld_out, ev); end
      n_tests++;
      if (full !== ef) begin n_fail++; $display("FAIL rnd_full%0d got %b exp %b", n, full, ef); end
      n_tests++;
      if (data_out !== ed) begin n_fail++; $display("FAIL rnd_data%0d got %h exp %h", n, data_out, ed); end
      n_tests++;
      if (wr_drop !== exp_drop) begin
        n_fail++; $display("FAIL rnd_drop%0d got %b exp %b", n, wr_drop, exp_drop);
      end
      n_tests++;
      if (got_sr !== exp_sr) begin n_fail++; $display("FAIL rnd_sr%0d got %b exp %b", n, got_sr, exp_sr); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_bad_ch();
    test_timeout();
    test_rescue();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
